frame_rr_arbiter: RTL and testbench
===================================

FRAME_RR_ARBITER -- requirements
Module: frame_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, meaning the number of ingress ports, legal range 2..16, and power of two not required.
REQ-002 The block SHALL have parameter DEST_W, default 2, meaning the destination field width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the stall limit used only under ARB_TIMEOUT_EN, legal range 2..65535.
REQ-004 The block SHALL have derived localparam SEL_W = max(1, clog2(NUM_PORTS)).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port ingress_valid, input, NUM_PORTS bits: per-ingress word valid.
REQ-008 The block SHALL have port ingress_dest, input, NUM_PORTS x DEST_W bits: per-ingress destination.
REQ-009 The block SHALL have port ingress_last, input, NUM_PORTS bits: per-ingress end-of-frame marker.
REQ-010 The block SHALL have port egress_index, input, DEST_W bits: this egress port's address, static after reset.
REQ-011 The block SHALL have port egress_ready, input, 1 bit: egress can accept a word.
REQ-012 The block SHALL have port select, output, SEL_W bits: index of the granted ingress.
REQ-013 The block SHALL have port grant, output, 1 bit: an ingress is locked to this egress.
REQ-014 The block SHALL have port ingress_ready, output, NUM_PORTS bits: one-hot-or-zero ready to the ingress ports.
REQ-015 The block SHALL have port egress_valid, output, 1 bit: the granted ingress word is valid.
REQ-016 The block SHALL have port egress_last, output, 1 bit: the granted ingress word is last.
REQ-017 The block SHALL have port timeout, output, 1 bit: a one-cycle pulse on a watchdog abort.

Function
REQ-018 The block SHALL define req[i] = ingress_valid[i] AND (ingress_dest[i] == egress_index).
REQ-019 The block SHALL use a two-state FSM with states IDLE and SEND, with the state, select and the rr pointer (SEL_W bits) all registered.
REQ-020 In IDLE with any req asserted, the block SHALL choose the first requesting index at or after the pointer, scanning upward modulo NUM_PORTS, then load select with it and enter SEND on the next edge.
REQ-021 In IDLE with no req asserted, the block SHALL hold its state, select and pointer.
REQ-022 grant SHALL equal (state == SEND), which gives a latency of one cycle from req to grant.
REQ-023 In SEND, the block SHALL drive ingress_ready[select] = egress_ready and all other ingress_ready bits to 0; in IDLE, all ingress_ready bits SHALL be 0.
REQ-024 In SEND, egress_valid SHALL equal ingress_valid[select] and egress_last SHALL equal ingress_last[select]; in IDLE, both SHALL be 0.
REQ-025 A transfer SHALL be defined as SEND AND egress_valid AND egress_ready.
REQ-026 A frame end SHALL be defined as a transfer with egress_last = 1.
REQ-027 On frame end, the block SHALL return to IDLE and set the pointer to (select+1) wrapped at NUM_PORTS, not at 2^SEL_W.
REQ-028 Changes to req of other ports or of the select port's dest during SEND SHALL be ignored, and the lock SHALL hold until frame end.
REQ-029 egress_ready low SHALL stall the block in SEND with no state change.
REQ-030 A single-word frame (last on the first word) SHALL be granted for exactly one cycle.
REQ-031 The block SHALL leave at least one IDLE cycle between consecutive frames.
REQ-032 With all ports requesting continuously, grants SHALL rotate 0,1,...,NUM_PORTS-1,0.
REQ-033 If the next grant winner has index greater than NUM_PORTS-1, that SHALL be a design error; the block SHALL never produce such a select value.

Reset
REQ-034 While reset is high, the block SHALL hold state = IDLE, pointer = 0, select = 0, timeout = 0, so grant, ingress_ready, egress_valid and egress_last are all 0.
REQ-035 Reset asserted mid-frame SHALL drop grant asynchronously, with no completion of the frame.
REQ-036 The first arbitration after reset deassertion SHALL start from pointer 0.

Configuration
REQ-037 With ARB_TIMEOUT_EN defined, a 16-bit stall counter SHALL clear on every transfer and on entry to SEND, and increment on each SEND cycle without a transfer.
REQ-038 With ARB_TIMEOUT_EN defined, when the stall counter reaches TIMEOUT_CYCLES-1 the block SHALL return to IDLE, set the pointer to select+1 wrapped, and pulse timeout for one cycle.
REQ-039 With ARB_TIMEOUT_EN undefined, the block SHALL contain no counter, timeout SHALL be tied to 0, and SEND SHALL wait indefinitely.

Verification
REQ-040 Bench scenario: NUM_PORTS=4, egress_index=2, port 1 sends a 3-word frame with dest 2 and egress_ready=1 -> grant rises 1 cycle after valid, select=1, 3 transfers, grant falls the cycle after last, and the pointer becomes 2.
REQ-041 Bench scenario: ports 0 to 3 all request dest 2, each with 2-word frames -> select order 0,1,2,3,0, with 1 IDLE cycle between frames.
REQ-042 Bench scenario: port 3 is granted and port 0 then requests mid-frame -> select stays 3 until frame end, the next grant goes to 0, and the pointer wraps 3->0.
REQ-043 Bench scenario: NUM_PORTS=3, port 2 completes a frame -> pointer=0 (not 3), and the next request from port 0 is granted.
REQ-044 Bench scenario: egress_ready=0 for 10 cycles mid-frame, then 1 -> no transfers and no ingress_ready during the stall, the frame completes, and timeout stays 0.
REQ-045 Bench scenario with ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: port 1 is granted, then ingress_valid[1]=0 -> timeout pulses exactly 8 SEND cycles after the last transfer, the block enters IDLE, pointer=2; reset asserted mid-frame separately -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/frame_rr_arbiter.sv
// -----------------------------------------------------------------------------
// frame_rr_arbiter
//   Frame-locked round-robin arbiter for one egress port. Each ingress whose
//   destination matches egress_index competes; the winner stays locked to the
//   egress until it delivers a word marked last. The round-robin pointer then
//   moves to the port after the winner.
//
// Parameters
//   NUM_PORTS      number of ingress ports (2..16, any value)
//   DEST_W         width of each destination field
//   TIMEOUT_CYCLES stall limit, used only when ARB_TIMEOUT_EN is defined
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   ingress_valid  per-ingress word valid
//   ingress_dest   per-ingress destination, port i at [i*DEST_W +: DEST_W]
//   ingress_last   per-ingress end-of-frame marker
//   egress_index   address of this egress (static after reset)
//   egress_ready   egress can accept a word
//   select         index of the granted ingress
//   grant          an ingress is locked to this egress
//   ingress_ready  one-hot-or-zero ready back to the ingress ports
//   egress_valid   granted ingress word valid
//   egress_last    granted ingress word is last
//   timeout        one-cycle pulse when the stall watchdog aborts a frame
//
// Build option
//   ARB_TIMEOUT_EN  adds a 16-bit stall watchdog; without it timeout is 0 and
//                   a locked frame waits indefinitely.
// -----------------------------------------------------------------------------
module frame_rr_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int DEST_W         = 2,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int SEL_W         = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        ingress_valid,
  input  logic [NUM_PORTS*DEST_W-1:0] ingress_dest,
  input  logic [NUM_PORTS-1:0]        ingress_last,
  input  logic [DEST_W-1:0]           egress_index,
  input  logic                        egress_ready,
  output logic [SEL_W-1:0]            select,
  output logic                        grant,
  output logic [NUM_PORTS-1:0]        ingress_ready,
  output logic                        egress_valid,
  output logic                        egress_last,
  output logic                        timeout
);

  localparam logic             STATE_IDLE = 1'b0;
  localparam logic             STATE_SEND = 1'b1;
  localparam logic [SEL_W-1:0] LAST_PORT  = SEL_W'(NUM_PORTS - 1);

  logic                 state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;

  logic [NUM_PORTS-1:0] req;
  logic                 win_found;
  logic [SEL_W-1:0]     win_idx;
  int unsigned          scan_idx;
  logic [SEL_W-1:0]     scan_sel;

  logic                 sending;
  logic                 xfer;
  logic                 frame_end;
  logic                 abort;
  logic [SEL_W-1:0]     ptr_wrap;

  // Request vector: valid word addressed to this egress.
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      req[i] = ingress_valid[i] &&
               (ingress_dest[i*DEST_W +: DEST_W] == egress_index);
    end
  end

  // First requester at or after the pointer, wrapping at NUM_PORTS. The
  // pointer is always below NUM_PORTS, so one subtraction wraps the scan.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    scan_sel  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= NUM_PORTS) begin
        scan_idx = scan_idx - NUM_PORTS;
      end
      scan_sel = SEL_W'(scan_idx);
      if (!win_found && req[scan_sel]) begin
        win_found = 1'b1;
        win_idx   = scan_sel;
      end
    end
  end

  assign sending      = (state_q == STATE_SEND);
  assign egress_valid = sending && ingress_valid[sel_q];
  assign egress_last  = sending && ingress_last[sel_q];
  assign xfer         = egress_valid && egress_ready;
  assign frame_end    = xfer && egress_last;
  assign ptr_wrap     = (sel_q == LAST_PORT) ? '0 : sel_q + SEL_W'(1);

  assign grant  = sending;
  assign select = sel_q;

  always_comb begin
    ingress_ready = '0;
    if (sending) begin
      ingress_ready[sel_q] = egress_ready;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] stall_q, stall_d;
  logic        timeout_q, timeout_d;

  // Abort only on a cycle with no transfer; a transfer always restarts the count.
  assign abort   = sending && !xfer && (stall_q == STALL_LIMIT);
  assign timeout = timeout_q;

  always_comb begin
    stall_d   = stall_q;
    timeout_d = abort;
    if (!sending) begin
      if (win_found) begin
        stall_d = '0;
      end
    end else if (xfer || abort) begin
      stall_d = '0;
    end else begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign abort              = 1'b0;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      STATE_IDLE: begin
        if (win_found) begin
          sel_d   = win_idx;
          state_d = STATE_SEND;
        end
      end
      default: begin
        if (frame_end || abort) begin
          state_d = STATE_IDLE;
          ptr_d   = ptr_wrap;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STATE_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_frame_rr_arbiter
//   Two arbiters share clock and reset: a 4-port instance driven from a table
//   of per-cycle vectors, and a 3-port instance (TIMEOUT_CYCLES=8) exercised
//   by hand-written sequences for pointer wrap, watchdog and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_frame_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  localparam logic [1:0] EIDX = 2'd2;

  logic [3:0] v4, l4, ir4;
  logic [7:0] d4;
  logic       r4, g4, ev4, el4, to4;
  logic [1:0] sel4;

  logic [2:0] v3, l3, ir3;
  logic [5:0] d3;
  logic       r3, g3, ev3, el3, to3;
  logic [1:0] sel3;

  frame_rr_arbiter #(.NUM_PORTS(4), .DEST_W(2)) dut4 (
    .clk(clk), .reset(reset),
    .ingress_valid(v4), .ingress_dest(d4), .ingress_last(l4),
    .egress_index(EIDX), .egress_ready(r4),
    .select(sel4), .grant(g4), .ingress_ready(ir4),
    .egress_valid(ev4), .egress_last(el4), .timeout(to4)
  );

  frame_rr_arbiter #(.NUM_PORTS(3), .DEST_W(2), .TIMEOUT_CYCLES(8)) dut3 (
    .clk(clk), .reset(reset),
    .ingress_valid(v3), .ingress_dest(d3), .ingress_last(l3),
    .egress_index(EIDX), .egress_ready(r3),
    .select(sel3), .grant(g3), .ingress_ready(ir3),
    .egress_valid(ev3), .egress_last(el3), .timeout(to3)
  );

  typedef struct {
    logic [3:0] valid;
    logic [7:0] dest;
    logic [3:0] last;
    logic       ready;
    logic       grant;
    logic [1:0] sel;
    logic [3:0] iready;
    logic       evalid;
    logic       elast;
  } vec_t;

  typedef struct {
    int   idx;
    vec_t v;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic void add(logic [3:0] v, logic [7:0] d, logic [3:0] l, logic r,
                              logic g, logic [1:0] s, logic [3:0] ir, logic ev, logic el);
    vec_t t;
    t.valid = v; t.dest = d; t.last = l; t.ready = r;
    t.grant = g; t.sel = s; t.iready = ir; t.evalid = ev; t.elast = el;
    vecs.push_back(t);
  endfunction

  // Each row is one clock cycle; expected outputs are for that same cycle.
  function automatic void build_table();
    // All four ports send 2-word frames: 0,1,2,3,0 with one idle cycle between.
    add(4'hF, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    add(4'hF, 8'hAA, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1, 1'b0);
    add(4'hF, 8'hAA, 4'h1, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1, 1'b1);
    add(4'hF, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    add(4'hF, 8'hAA, 4'h0, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1, 1'b0);
    add(4'hF, 8'hAA, 4'h2, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1, 1'b1);
    add(4'hF, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 1'b0);
    add(4'hF, 8'hAA, 4'h0, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1, 1'b0);
    add(4'hF, 8'hAA, 4'h4, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1, 1'b1);
    add(4'hF, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd2, 4'h0, 1'b0, 1'b0);
    add(4'hF, 8'hAA, 4'h0, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1, 1'b0);
    add(4'hF, 8'hAA, 4'h8, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1, 1'b1);
    add(4'hF, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd3, 4'h0, 1'b0, 1'b0);
    add(4'hF, 8'hAA, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1, 1'b0);
    add(4'hF, 8'hAA, 4'h1, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1, 1'b1);
    add(4'h0, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    // Port 1 alone, 3-word frame; then everyone single-word shows pointer = 2.
    add(4'h2, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    add(4'h2, 8'hAA, 4'h0, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1, 1'b0);
    add(4'h2, 8'hAA, 4'h0, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1, 1'b0);
    add(4'h2, 8'hAA, 4'h2, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1, 1'b1);
    add(4'h0, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 1'b0);
    add(4'hF, 8'hAA, 4'hF, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 1'b0);
    add(4'hF, 8'hAA, 4'hF, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1, 1'b1);
    add(4'h0, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd2, 4'h0, 1'b0, 1'b0);
    // Port 3 locked; port 0 joins mid-frame and port 3's dest moves away.
    add(4'h8, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd2, 4'h0, 1'b0, 1'b0);
    add(4'h8, 8'hAA, 4'h0, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1, 1'b0);
    add(4'h9, 8'hAA, 4'h0, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1, 1'b0);
    add(4'h9, 8'h2A, 4'h8, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1, 1'b1);
    add(4'h1, 8'hAA, 4'h1, 1'b1, 1'b0, 2'd3, 4'h0, 1'b0, 1'b0);
    add(4'h1, 8'hAA, 4'h1, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1, 1'b1);
    add(4'h0, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    // Valid words to other destinations never request.
    add(4'hF, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    add(4'hF, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    add(4'hF, 8'h9C, 4'h8, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    add(4'hF, 8'h9C, 4'h8, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1, 1'b1);
    add(4'h0, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd3, 4'h0, 1'b0, 1'b0);
    // Port 0: one transfer, 10-cycle egress stall with last pending, then finish.
    add(4'h1, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd3, 4'h0, 1'b0, 1'b0);
    add(4'h1, 8'hAA, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      add(4'h1, 8'hAA, 4'h1, 1'b0, 1'b1, 2'd0, 4'h0, 1'b1, 1'b1);
    end
    add(4'h1, 8'hAA, 4'h1, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1, 1'b1);
    add(4'h0, 8'hAA, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check($sformatf("vec%0d.grant", mon_e.idx), g4, mon_e.v.grant);
      check($sformatf("vec%0d.select", mon_e.idx), sel4, mon_e.v.sel);
      check($sformatf("vec%0d.ingress_ready", mon_e.idx), ir4, mon_e.v.iready);
      check($sformatf("vec%0d.egress_valid", mon_e.idx), ev4, mon_e.v.evalid);
      check($sformatf("vec%0d.egress_last", mon_e.idx), el4, mon_e.v.elast);
      check($sformatf("vec%0d.timeout", mon_e.idx), to4, 1'b0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    v4 = 4'hF; d4 = 8'hAA; l4 = 4'hF; r4 = 1'b1;
    v3 = 3'h7; d3 = 6'h2A; l3 = 3'h7; r3 = 1'b1;
    build_table();

    // Held in reset with every port requesting.
    sample();
    sample();
    check("rst.grant4", g4, 1'b0);
    check("rst.select4", sel4, 2'd0);
    check("rst.ingress_ready4", ir4, 4'h0);
    check("rst.egress_valid4", ev4, 1'b0);
    check("rst.egress_last4", el4, 1'b0);
    check("rst.timeout4", to4, 1'b0);
    check("rst.grant3", g3, 1'b0);
    check("rst.ingress_ready3", ir3, 3'h0);
    check("rst.timeout3", to3, 1'b0);

    tick();
    reset = 1'b0;
    v4 = '0; l4 = '0;
    v3 = '0; l3 = '0;

    foreach (vecs[i]) begin
      tick();
      v4 = vecs[i].valid;
      d4 = vecs[i].dest;
      l4 = vecs[i].last;
      r4 = vecs[i].ready;
      exp_q.push_back('{i, vecs[i]});
    end
    sample();
    sample();
    check("sb.drain", exp_q.size(), 0);

    // 3 ports: pointer after port 2 wraps to 0.
    tick();
    v3 = 3'b100; d3 = 6'h2A; l3 = 3'b100; r3 = 1'b1;
    sample();
    check("p3.idle.grant", g3, 1'b0);
    tick();
    sample();
    check("p3.grant", g3, 1'b1);
    check("p3.select", sel3, 2'd2);
    check("p3.ingress_ready", ir3, 3'b100);
    check("p3.egress_last", el3, 1'b1);
    tick();
    v3 = 3'b011; l3 = 3'b011;
    sample();
    check("p3.gap.grant", g3, 1'b0);
    tick();
    sample();
    check("p3.wrap.select", sel3, 2'd0);
    check("p3.wrap.grant", g3, 1'b1);
    check("p3.wrap.ingress_ready", ir3, 3'b001);
    tick();
    v3 = '0; l3 = '0;
    sample();
    check("p3.end.grant", g3, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Port 1 transfers once then drops valid: abort after 8 stalled cycles.
    tick();
    v3 = 3'b010; l3 = 3'b000;
    sample();
    check("to.idle.grant", g3, 1'b0);
    tick();
    sample();
    check("to.grant", g3, 1'b1);
    check("to.select", sel3, 2'd1);
    check("to.egress_valid", ev3, 1'b1);
    tick();
    v3 = '0;
    for (int j = 1; j <= 8; j++) begin
      sample();
      check($sformatf("to.stall%0d.grant", j), g3, 1'b1);
      check($sformatf("to.stall%0d.timeout", j), to3, 1'b0);
      tick();
    end
    sample();
    check("to.pulse", to3, 1'b1);
    check("to.abort.grant", g3, 1'b0);
    tick();
    v3 = 3'b111; l3 = 3'b111;
    sample();
    check("to.pulse_end", to3, 1'b0);
    check("to.after.grant", g3, 1'b0);
    tick();
    sample();
    check("to.ptr.select", sel3, 2'd2);
    check("to.ptr.grant", g3, 1'b1);
    tick();
    v3 = '0; l3 = '0;
`endif

    // Reset mid-frame drops everything at once; arbitration restarts from 0.
    tick();
    v3 = 3'b100; l3 = 3'b000;
    sample();
    tick();
    sample();
    check("mid.grant_before", g3, 1'b1);
    check("mid.select_before", sel3, 2'd2);
    #2;
    reset = 1'b1;
    #1;
    check("mid.grant", g3, 1'b0);
    check("mid.select", sel3, 2'd0);
    check("mid.ingress_ready", ir3, 3'h0);
    check("mid.egress_valid", ev3, 1'b0);
    check("mid.egress_last", el3, 1'b0);
    check("mid.timeout", to3, 1'b0);
    check("mid.grant4", g4, 1'b0);
    tick();
    reset = 1'b0;
    v3 = 3'b111; l3 = 3'b111;
    sample();
    check("rel.idle.grant", g3, 1'b0);
    tick();
    sample();
    check("rel.first.select", sel3, 2'd0);
    check("rel.first.grant", g3, 1'b1);
    tick();
    v3 = '0; l3 = '0;
    sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
